// File: rtl/pixel_plot_fifo_if.sv
// Pixel stream in / VGA plot port out bundle for pixel_plot_fifo.
// The producer and the adapter side share one interface; the FIFO uses the slave view.
interface pixel_plot_fifo_if #(
    parameter int COLOUR_W = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_x;
    logic [7:0]          in_y;
    logic [COLOUR_W-1:0] in_colour;
    logic                in_last;
    logic                out_en;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                prim_done;
    logic                busy;

    modport master (
        output in_valid, in_x, in_y, in_colour, in_last, out_en,
        input  in_ready, vga_x, vga_y, vga_colour, vga_plot, prim_done, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, in_last, out_en,
        output in_ready, vga_x, vga_y, vga_colour, vga_plot, prim_done, busy
    );
endinterface

// File: rtl/pixel_plot_fifo.sv
// Clipping pixel FIFO between the rectangle generator and the VGA adapter plot port.
// Optional PLOT_STATS_EN adds saturating plotted/clipped pixel counters.
module pixel_plot_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    pixel_plot_fifo_if.slave bus
`ifdef PLOT_STATS_EN
    ,
    output logic [15:0]      plotted_cnt,
    output logic [15:0]      clipped_cnt
`endif
);
    localparam int         AW          = $clog2(DEPTH);
    localparam int         EW          = 8 + 7 + COLOUR_W + 2;
    localparam logic [8:0] LP_SCREEN_W = 9'(SCREEN_W);
    localparam logic [8:0] LP_SCREEN_H = 9'(SCREEN_H);

    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic [EW-1:0]        r_mem [DEPTH];
    logic [7:0]           r_vga_x;
    logic [6:0]           r_vga_y;
    logic [COLOUR_W-1:0]  r_vga_colour;
    logic                 r_vga_plot;
    logic                 r_prim_done;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_skip;
    logic                 w_accept;
    logic                 w_write;
    logic                 w_pop;
    logic [EW-1:0]        w_entry;
    logic [EW-1:0]        w_head;
    logic [7:0]           w_head_x;
    logic [6:0]           w_head_y;
    logic [COLOUR_W-1:0]  w_head_colour;
    logic                 w_head_last;
    logic                 w_head_skip;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_skip   = ({1'b0, bus.in_x} >= LP_SCREEN_W) || ({1'b0, bus.in_y} >= LP_SCREEN_H);
    assign w_accept = bus.in_valid && !w_full;
    // Off-screen pixels vanish unless they carry the end-of-primitive marker.
    assign w_write  = w_accept && (!w_skip || bus.in_last);
    assign w_pop    = bus.out_en && !w_empty;
    assign w_entry  = {bus.in_x, bus.in_y[6:0], bus.in_colour, bus.in_last, w_skip};
    assign w_head   = r_mem[r_rptr[AW-1:0]];
    assign {w_head_x, w_head_y, w_head_colour, w_head_last, w_head_skip} = w_head;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_write) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)   r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && w_write) r_mem[r_wptr[AW-1:0]] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_prim_done  <= 1'b0;
        end else if (w_pop) begin
            r_vga_x      <= w_head_x;
            r_vga_y      <= w_head_y;
            r_vga_colour <= w_head_colour;
            r_vga_plot   <= !w_head_skip;
            r_prim_done  <= w_head_last;
        end else begin
            r_vga_plot   <= 1'b0;
            r_prim_done  <= 1'b0;
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;
    assign bus.prim_done  = r_prim_done;
    assign bus.busy       = !w_empty || r_vga_plot || r_prim_done;

`ifdef PLOT_STATS_EN
    logic [15:0] r_plotted_cnt;
    logic [15:0] r_clipped_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_plotted_cnt <= '0;
            r_clipped_cnt <= '0;
        end else begin
            if (r_vga_plot && (r_plotted_cnt != 16'hFFFF))
                r_plotted_cnt <= r_plotted_cnt + 16'd1;
            if (w_accept && w_skip && (r_clipped_cnt != 16'hFFFF))
                r_clipped_cnt <= r_clipped_cnt + 16'd1;
        end
    end

    assign plotted_cnt = r_plotted_cnt;
    assign clipped_cnt = r_clipped_cnt;
`endif
endmodule

// File: tb/tb_pixel_plot_fifo.sv
// Self-checking bench for pixel_plot_fifo: directed scenarios plus a random stream,
// all outputs compared against a queue of expected plot/done events.
module tb_pixel_plot_fifo;
    localparam int DEPTH    = 8;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    typedef struct {
        logic                plot;
        logic [7:0]          x;
        logic [6:0]          y;
        logic [COLOUR_W-1:0] c;
        logic                done;
    } ev_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pixel_plot_fifo_if #(.COLOUR_W(COLOUR_W)) bus ();

`ifdef PLOT_STATS_EN
    logic [15:0] plotted_cnt;
    logic [15:0] clipped_cnt;
`endif

    pixel_plot_fifo #(
        .DEPTH(DEPTH), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .COLOUR_W(COLOUR_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus.slave)
`ifdef PLOT_STATS_EN
        ,
        .plotted_cnt(plotted_cnt),
        .clipped_cnt(clipped_cnt)
`endif
    );

    int  checks = 0;
    int  errors = 0;
    int  n_plot = 0;
    int  n_done = 0;
    int  plotted_m = 0;
    int  clipped_m = 0;
    bit  rnd_done = 0;
    ev_t exp_q[$];
    ev_t mon_e;

    // Reference: every accepted pixel becomes at most one output event, in order.
    task automatic model_accept(input logic [7:0] x, input logic [7:0] y,
                                input logic [COLOUR_W-1:0] c, input logic last);
        logic [6:0] y7;
        bit off;
        y7  = y[6:0];
        off = (int'(x) >= SCREEN_W) || (int'(y) >= SCREEN_H);
        if (!off) begin
            exp_q.push_back('{plot: 1'b1, x: x, y: y7, c: c, done: last});
            plotted_m++;
        end else begin
            clipped_m++;
            if (last) exp_q.push_back('{plot: 1'b0, x: x, y: y7, c: c, done: 1'b1});
        end
    endtask

    always @(negedge clk) begin
        if (resetn && (bus.vga_plot || bus.prim_done)) begin
            if (bus.vga_plot)  n_plot++;
            if (bus.prim_done) n_done++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra got plot=%0b done=%0b x=%0d y=%0d exp no output",
                         bus.vga_plot, bus.prim_done, bus.vga_x, bus.vga_y);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.vga_plot !== mon_e.plot || bus.prim_done !== mon_e.done ||
                    (mon_e.plot && (bus.vga_x !== mon_e.x || bus.vga_y !== mon_e.y ||
                                    bus.vga_colour !== mon_e.c))) begin
                    errors++;
                    $display("FAIL stream_order got plot=%0b done=%0b (%0d,%0d,c%0d) exp plot=%0b done=%0b (%0d,%0d,c%0d)",
                             bus.vga_plot, bus.prim_done, bus.vga_x, bus.vga_y, bus.vga_colour,
                             mon_e.plot, mon_e.done, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_px(input logic [7:0] x, input logic [7:0] y,
                           input logic [COLOUR_W-1:0] c, input logic last);
        int guard;
        guard         = 0;
        bus.in_valid  = 1'b1;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_colour = c;
        bus.in_last   = last;
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got in_ready=0 for %0d cycles exp 1", guard);
        end else begin
            model_accept(x, y, c, last);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard      = 0;
        bus.out_en = 1'b1;
        while ((exp_q.size() != 0 || bus.busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL drain got pending=%0d busy=%0b exp 0 0", exp_q.size(), bus.busy);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got in_ready=%0b busy=%0b exp 1 0", bus.in_ready, bus.busy);
        end
        checks++;
        if (bus.vga_plot !== 1'b0 || bus.prim_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got plot=%0b done=%0b exp 0 0", bus.vga_plot, bus.prim_done);
        end
        checks++;
        if (bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0 || bus.vga_colour !== '0) begin
            errors++;
            $display("FAIL reset_coords got %0d,%0d,%0d exp 0,0,0", bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        resetn = 1'b1;
        exp_q.delete();
        plotted_m = 0;
        clipped_m = 0;
        @(negedge clk);
`ifdef PLOT_STATS_EN
        checks++;
        if (plotted_cnt !== 16'd0 || clipped_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats got %0d %0d exp 0 0", plotted_cnt, clipped_cnt);
        end
`endif
    endtask

    task automatic test_single();
        bus.out_en = 1'b1;
        push_px(8'd5, 8'd7, 3'd3, 1'b1);
        checks++;
        if (bus.vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL single_early got plot=%0b exp 0", bus.vga_plot);
        end
        @(negedge clk);
        checks++;
        if (bus.vga_plot !== 1'b1 || bus.prim_done !== 1'b1 || bus.vga_x !== 8'd5 ||
            bus.vga_y !== 7'd7 || bus.vga_colour !== 3'd3) begin
            errors++;
            $display("FAIL single_out got plot=%0b done=%0b (%0d,%0d,c%0d) exp 1 1 (5,7,c3)",
                     bus.vga_plot, bus.prim_done, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%0b plot=%0b exp 0 0", bus.busy, bus.vga_plot);
        end
    endtask

    task automatic test_fill();
        int p0;
        logic [7:0] x9;
        logic [7:0] y9;
        logic [COLOUR_W-1:0] c9;
        bus.out_en = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push_px(8'($urandom_range(0, SCREEN_W-1)), 8'($urandom_range(0, SCREEN_H-1)),
                    COLOUR_W'($urandom), 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got in_ready=%0b busy=%0b exp 0 1", bus.in_ready, bus.busy);
        end
        x9 = 8'($urandom_range(0, SCREEN_W-1));
        y9 = 8'($urandom_range(0, SCREEN_H-1));
        c9 = COLOUR_W'($urandom);
        p0 = n_plot;
        bus.in_valid = 1'b1;
        bus.in_x = x9; bus.in_y = y9; bus.in_colour = c9; bus.in_last = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || n_plot != p0) begin
            errors++;
            $display("FAIL fill_hold got in_ready=%0b plots=%0d exp 0 0", bus.in_ready, n_plot - p0);
        end
        bus.out_en = 1'b1;
        push_px(x9, y9, c9, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.vga_plot !== 1'b1) begin
                errors++;
                $display("FAIL fill_rate got plot=%0b at beat %0d exp 1", bus.vga_plot, i + 2);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_clip();
        int p0, d0;
`ifdef PLOT_STATS_EN
        logic [15:0] cl0;
        cl0 = clipped_cnt;
`endif
        p0 = n_plot;
        d0 = n_done;
        bus.out_en = 1'b1;
        push_px(8'd160, 8'd0, 3'd1, 1'b0);
        push_px(8'd3, 8'd120, 3'd2, 1'b1);
        drain();
        checks++;
        if (n_plot != p0 || n_done != d0 + 1) begin
            errors++;
            $display("FAIL clip_counts got plots=%0d dones=%0d exp 0 1", n_plot - p0, n_done - d0);
        end
`ifdef PLOT_STATS_EN
        checks++;
        if (clipped_cnt !== cl0 + 16'd2) begin
            errors++;
            $display("FAIL clip_stat got %0d exp %0d", clipped_cnt, cl0 + 16'd2);
        end
`endif
    endtask

    task automatic test_full_pop();
        logic [7:0] xp;
        xp = 8'($urandom_range(0, SCREEN_W-1));
        bus.out_en = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push_px(8'(i * 3), 8'(i), COLOUR_W'(i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_x = xp; bus.in_y = 8'd50; bus.in_colour = 3'd6; bus.in_last = 1'b1;
        bus.out_en = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_full got in_ready=%0b exp 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_refused got in_ready=%0b exp 1", bus.in_ready);
        end
        model_accept(xp, 8'd50, 3'd6, 1'b1);
        bus.out_en = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_accept got in_ready=%0b exp 0", bus.in_ready);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int p0;
        bus.out_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push_px(8'(10 + i), 8'(20 + i), COLOUR_W'(i), (i == 3) ? 1'b1 : 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got busy=%0b exp 1", bus.busy);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        plotted_m = 0;
        clipped_m = 0;
        checks++;
        if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state got plot=%0b busy=%0b in_ready=%0b exp 0 0 1",
                     bus.vga_plot, bus.busy, bus.in_ready);
        end
        p0 = n_plot + n_done;
        bus.out_en = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (n_plot + n_done != p0) begin
            errors++;
            $display("FAIL rstmid_ghost got %0d outputs exp 0", n_plot + n_done - p0);
        end
    endtask

    task automatic test_rect();
        int p0, d0, vis;
        p0  = n_plot;
        d0  = n_done;
        vis = 0;
        bus.out_en = 1'b1;
        for (int y = 115; y < 125; y++)
            for (int x = 150; x < 170; x++) begin
                if (x < SCREEN_W && y < SCREEN_H) vis++;
                push_px(8'(x), 8'(y), 3'd5, (x == 169 && y == 124) ? 1'b1 : 1'b0);
            end
        drain();
        checks++;
        if (n_plot != p0 + vis || n_done != d0 + 1) begin
            errors++;
            $display("FAIL rect_counts got plots=%0d dones=%0d exp %0d 1", n_plot - p0, n_done - d0, vis);
        end
    endtask

    task automatic test_random();
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    push_px(8'($urandom_range(0, 191)), 8'($urandom_range(0, 143)),
                            COLOUR_W'($urandom), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    bus.out_en = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
`ifdef PLOT_STATS_EN
        checks++;
        if (int'(plotted_cnt) != plotted_m || int'(clipped_cnt) != clipped_m) begin
            errors++;
            $display("FAIL stats got plotted=%0d clipped=%0d exp %0d %0d",
                     plotted_cnt, clipped_cnt, plotted_m, clipped_m);
        end
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_colour = '0;
        bus.in_last   = 1'b0;
        bus.out_en    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_clip();
        test_full_pop();
        test_reset_mid();
        test_rect();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
